// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the add/sub/lw/sw/beq/j datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback and counts retirements.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             alu_sub,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RTWB   = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        opcode_s;
  logic [5:0]        funct_s;
  logic              is_mem_s;
  logic              is_rtype_s;
  logic              fn_sub_s;
  logic              instr_unused;

  assign opcode_s     = instr[31:26];
  assign funct_s      = instr[5:0];
  assign fn_sub_s     = (funct_s == FN_SUB);
  assign is_mem_s     = (opcode_s == OP_LW) || (opcode_s == OP_SW);
  assign is_rtype_s   = (opcode_s == OP_RTYPE) && ((funct_s == FN_ADD) || fn_sub_s);
  // Register/immediate fields feed the datapath directly, not this controller.
  assign instr_unused = ^instr[25:6];
  assign retired_cnt  = cnt_q;

  // Next-state, Moore/Mealy output decode and retire counter update.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_sub    = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
        else           state_d = FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (is_mem_s)                 state_d = MEMADR;
        else if (is_rtype_s)          state_d = EXEC;
        else if (opcode_s == OP_BEQ)  state_d = BRANCH;
        else if (opcode_s == OP_J)    state_d = JUMP;
        else begin
          illegal = 1'b1;
          state_d = FETCH;
        end
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode_s == OP_LW) state_d = MEMRD;
        else                   state_d = MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = MEMWB;
        else           state_d = MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        retire  = mem_ready;
        if (mem_ready) state_d = FETCH;
        else           state_d = MEMWR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_sub   = fn_sub_s;
        state_d   = RTWB;
      end
      RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        alu_src_a = 1'b1;
        alu_sub   = fn_sub_s;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_sub   = 1'b1;
        pc_src    = 2'b01;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = IDLE;
    endcase
    if (retire) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else        cnt_d = cnt_q;
  end

  // State and retired-instruction counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: per-instruction step queues drive a
// behavioural model compared every cycle, plus literal cycle/retire/reset expectations.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   instr = 32'h0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]    pc_src, alu_src_b;
  logic          alu_src_a, alu_sub, reg_write, reg_dst, mem_to_reg, retire, illegal;
  logic [CW-1:0] retired_cnt;

  typedef struct packed {
    logic mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic alu_src_a;
    logic [1:0] alu_src_b;
    logic alu_sub, reg_write, reg_dst, mem_to_reg, retire, illegal;
  } outs_t;

  typedef enum int {K_IDLE, K_FETCH, K_DEC, K_ADDR, K_RD, K_WB, K_WR, K_EX, K_RT, K_BR, K_J} step_t;

  int      n_checks = 0;
  int      n_fail = 0;
  bit      check_en = 1'b0;
  outs_t   exp_o;
  outs_t   dut_o;
  int      model_cnt = 0;
  step_t   cur_step = K_IDLE;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_sub(alu_sub), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .retire(retire), .illegal(illegal), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  assign dut_o = '{mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                   alu_src_b, alu_sub, reg_write, reg_dst, mem_to_reg, retire, illegal};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (step %0d, t=%0t)", name, got, exp, cur_step, $time);
    end
  endtask

  // 0 lw, 1 sw, 2 add/sub, 3 beq, 4 j, 5 unsupported
  function automatic int kind(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h23) return 0;
    if (op == 6'h2B) return 1;
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) return 2;
    if (op == 6'h04) return 3;
    if (op == 6'h02) return 4;
    return 5;
  endfunction

  function automatic outs_t expect_outs(input step_t s, input logic [31:0] ins,
                                        input logic rdy, input logic z);
    outs_t o;
    logic  is_sub;
    o = '0;
    is_sub = (ins[5:0] == 6'h22);
    case (s)
      K_FETCH: begin o.mem_req = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      K_DEC:   begin o.alu_src_b = 2'b11; o.illegal = (kind(ins) == 5); end
      K_ADDR:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      K_RD:    begin o.mem_req = 1'b1; o.iord = 1'b1; end
      K_WB:    begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.retire = 1'b1; end
      K_WR:    begin o.mem_req = 1'b1; o.mem_we = 1'b1; o.iord = 1'b1; o.retire = rdy; end
      K_EX:    begin o.alu_src_a = 1'b1; o.alu_sub = is_sub; end
      K_RT:    begin o.reg_write = 1'b1; o.reg_dst = 1'b1; o.alu_src_a = 1'b1;
                     o.alu_sub = is_sub; o.retire = 1'b1; end
      K_BR:    begin o.alu_src_a = 1'b1; o.alu_sub = 1'b1; o.pc_src = 2'b01;
                     o.pc_write = z; o.retire = 1'b1; end
      K_J:     begin o.pc_src = 2'b10; o.pc_write = 1'b1; o.retire = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Every-cycle comparison of DUT outputs and counter against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("outputs", 32'(dut_o), 32'(exp_o));
      chk("retired_cnt", 32'(retired_cnt), 32'(model_cnt));
    end
  end

  task automatic do_idle();
    cur_step  = K_IDLE;
    mem_ready = 1'($urandom_range(1, 0));
    exp_o     = '0;
    check_en  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Run one instruction; fw/mw are wait cycles in FETCH and MEMRD/MEMWR.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z,
                           input int exp_cycles, input int exp_ret, input bit do_rst);
    step_t q[$];
    int    wctr, cycles, start_cnt, ir_pulses, w;
    bit    mem_step, rdy, aborted;
    instr = ins;
    q = '{K_FETCH, K_DEC};
    case (kind(ins))
      0: q = {q, K_ADDR, K_RD, K_WB};
      1: q = {q, K_ADDR, K_WR};
      2: q = {q, K_EX, K_RT};
      3: q.push_back(K_BR);
      4: q.push_back(K_J);
      default: ;
    endcase
    wctr = 0; cycles = 0; ir_pulses = 0; aborted = 1'b0;
    start_cnt = int'(retired_cnt);
    while (q.size() > 0) begin
      cur_step = q[0];
      mem_step = (cur_step == K_FETCH || cur_step == K_RD || cur_step == K_WR);
      w = (cur_step == K_FETCH) ? fw : mw;
      if (mem_step) rdy = (wctr >= w);
      else          rdy = 1'($urandom_range(1, 0));
      mem_ready = rdy;
      zero      = (cur_step == K_BR) ? z : 1'($urandom_range(1, 0));
      exp_o     = expect_outs(cur_step, ins, rdy, zero);
      check_en  = 1'b1;
      if (do_rst && cur_step == K_RD && wctr == 2) begin
        check_en = 1'b0;
        #2;
        chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_outputs", 32'(dut_o), 32'd0);
        chk("reset_cnt", 32'(retired_cnt), 32'd0);
        model_cnt = 0;
        aborted = 1'b1;
        break;
      end
      #3;
      if (ir_write === 1'b1) ir_pulses++;
      @(posedge clk);
      cycles++;
      if (exp_o.retire) model_cnt = (model_cnt + 1) % (1 << CW);
      if (mem_step && !rdy) wctr++;
      else begin
        void'(q.pop_front());
        wctr = 0;
      end
      #1;
    end
    if (!aborted && exp_cycles >= 0) begin
      chk("instr_cycles", 32'(cycles), 32'(exp_cycles));
      chk("ir_write_pulses", 32'(ir_pulses), 32'd1);
      chk("cnt_delta", 32'(retired_cnt), 32'((start_cnt + exp_ret) % (1 << CW)));
    end
  endtask

  initial begin
    logic [31:0] ins;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_outputs_init", 32'(dut_o), 32'd0);
    chk("reset_cnt_init", 32'(retired_cnt), 32'd0);
    rst_n = 1'b1;
    do_idle();

    // 17 jumps with a 4-bit counter wrap to 1.
    for (int i = 0; i < 17; i++) run_instr(32'h08000000, 0, 0, 1'b0, 3, 1, 1'b0);
    chk("wrap_cnt", 32'(retired_cnt), 32'd1);

    run_instr(32'h02328020, 0, 0, 1'b0, 4, 1, 1'b0);  // add
    run_instr(32'h02328022, 0, 0, 1'b0, 4, 1, 1'b0);  // sub
    run_instr(32'h8E300020, 2, 2, 1'b0, 9, 1, 1'b0);  // lw, 2+2 waits
    run_instr(32'h8E300020, 0, 0, 1'b0, 5, 1, 1'b0);  // lw
    run_instr(32'hAE300020, 0, 0, 1'b0, 4, 1, 1'b0);  // sw
    run_instr(32'hAE300020, 1, 3, 1'b0, 8, 1, 1'b0);  // sw with waits
    run_instr(32'h121100C8, 0, 0, 1'b1, 3, 1, 1'b0);  // beq taken
    run_instr(32'h121100C8, 0, 0, 1'b0, 3, 1, 1'b0);  // beq not taken
    run_instr(32'h3F000000, 0, 0, 1'b0, 2, 0, 1'b0);  // bad opcode
    run_instr(32'h0232802A, 0, 0, 1'b0, 2, 0, 1'b0);  // bad funct
    run_instr(32'h08000000, 0, 0, 1'b0, 3, 1, 1'b0);  // j

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(7, 0))
        0: ins = {6'h23, 26'($urandom)};
        1: ins = {6'h2B, 26'($urandom)};
        2: ins = {6'h00, 20'($urandom), 6'h20};
        3: ins = {6'h00, 20'($urandom), 6'h22};
        4: ins = {6'h04, 26'($urandom)};
        5: ins = {6'h02, 26'($urandom)};
        6: ins = {6'h00, 26'($urandom)};
        default: ins = $urandom;
      endcase
      run_instr(ins, $urandom_range(2, 0), $urandom_range(2, 0), 1'($urandom_range(1, 0)),
                -1, 0, 1'b0);
    end

    // Reset asserted while MEMRD is waiting, then recovery.
    run_instr(32'h8E300020, 0, 5, 1'b0, -1, 0, 1'b1);
    @(posedge clk);
    #1;
    chk("reset_held_outputs", 32'(dut_o), 32'd0);
    rst_n = 1'b1;
    do_idle();
    run_instr(32'h02328020, 0, 0, 1'b0, 4, 1, 1'b0);
    chk("post_reset_cnt", 32'(retired_cnt), 32'd1);
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
